// File: rtl/rst_seq.sv
// Power-on reset sequencer: PLL lock -> system hold -> SDRAM init -> CPU hold -> run.
module rst_seq #(
    parameter int unsigned HOLD_CYCLES     = 1024,
    parameter int unsigned CPU_HOLD_CYCLES = 4096,
    parameter int unsigned INIT_TIMEOUT    = 65536
) (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic pll_locked,
    input  logic sdram_init_done,
    input  logic soft_rst,
    output logic sys_rst,
    output logic sdram_rst,
    output logic cpu_rst_n,
    output logic ready,
    output logic init_err
);

    localparam int unsigned MAX_HC  = (HOLD_CYCLES > CPU_HOLD_CYCLES) ? HOLD_CYCLES : CPU_HOLD_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_HC > INIT_TIMEOUT) ? MAX_HC : INIT_TIMEOUT;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CPU_LAST  = CNT_W'(CPU_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_TIMEOUT - 1);

    typedef enum logic [2:0] {
        WAIT_LOCK  = 3'd0,
        HOLD       = 3'd1,
        SDRAM_INIT = 3'd2,
        CPU_HOLD   = 3'd3,
        RUN        = 3'd4
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [1:0]       lock_sync;
    logic             locked_s;
    logic             err_set;

    logic sys_rst_d;
    logic sdram_rst_d;
    logic cpu_rst_n_d;
    logic ready_d;

    assign locked_s = lock_sync[1];

    // Two-flop synchroniser for the asynchronous PLL lock.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_sync <= 2'b00;
        end else begin
            lock_sync <= {lock_sync[0], pll_locked};
        end
    end

    // State and shared counter register.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state and counter logic; loss of lock overrides everything.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        err_set   = 1'b0;
        case (state)
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (cnt == HOLD_LAST) begin
                    state_nxt = SDRAM_INIT;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            SDRAM_INIT: begin
                if (sdram_init_done) begin
                    state_nxt = CPU_HOLD;
                end else if (cnt == INIT_LAST) begin
                    state_nxt = WAIT_LOCK;
                    err_set   = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            CPU_HOLD: begin
                if (cnt == CPU_LAST) begin
                    state_nxt = RUN;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            RUN: begin
                if (soft_rst) begin
                    state_nxt = CPU_HOLD;
                end
            end
            default: begin
                state_nxt = WAIT_LOCK;
            end
        endcase
        if (!locked_s && (state != WAIT_LOCK)) begin
            state_nxt = WAIT_LOCK;
            cnt_nxt   = '0;
            err_set   = 1'b0;
        end
    end

    // Output decode from the next state so outputs move with the state.
    always_comb begin
        sys_rst_d   = 1'b1;
        sdram_rst_d = 1'b1;
        cpu_rst_n_d = 1'b0;
        ready_d     = 1'b0;
        case (state_nxt)
            SDRAM_INIT, CPU_HOLD: begin
                sys_rst_d   = 1'b0;
                sdram_rst_d = 1'b0;
            end
            RUN: begin
                sys_rst_d   = 1'b0;
                sdram_rst_d = 1'b0;
                cpu_rst_n_d = 1'b1;
                ready_d     = 1'b1;
            end
            default: begin
                sys_rst_d   = 1'b1;
                sdram_rst_d = 1'b1;
            end
        endcase
    end

    // Output registers; init_err is sticky until rst_n.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            sys_rst   <= 1'b1;
            sdram_rst <= 1'b1;
            cpu_rst_n <= 1'b0;
            ready     <= 1'b0;
            init_err  <= 1'b0;
        end else begin
            sys_rst   <= sys_rst_d;
            sdram_rst <= sdram_rst_d;
            cpu_rst_n <= cpu_rst_n_d;
            ready     <= ready_d;
            init_err  <= init_err | err_set;
        end
    end

endmodule

// File: tb/tb_rst_seq.sv
// Scoreboard bench for rst_seq: expected output levels are queued per edge number.
module tb_rst_seq;

    localparam int unsigned H_CYC = 8;
    localparam int unsigned C_CYC = 16;
    localparam int unsigned T_CYC = 32;

    // Output vector order: {sys_rst, sdram_rst, cpu_rst_n, ready, init_err}
    localparam logic [4:0] V_RST  = 5'b11000;
    localparam logic [4:0] V_MID  = 5'b00000;
    localparam logic [4:0] V_RUN  = 5'b00110;
    localparam logic [4:0] V_RSTE = 5'b11001;
    localparam logic [4:0] V_MIDE = 5'b00001;
    localparam logic [4:0] V_RUNE = 5'b00111;

    typedef struct {
        int         edge_no;
        logic [4:0] val;
        string      tag;
    } sb_t;

    logic sys_clk = 1'b0;
    logic rst_n;
    logic pll_locked;
    logic sdram_init_done;
    logic soft_rst;
    logic sys_rst;
    logic sdram_rst;
    logic cpu_rst_n;
    logic ready;
    logic init_err;
    logic [4:0] outs;

    int  n_vec  = 0;
    int  n_miss = 0;
    int  edge_n;
    sb_t sb[$];

    rst_seq #(
        .HOLD_CYCLES    (H_CYC),
        .CPU_HOLD_CYCLES(C_CYC),
        .INIT_TIMEOUT   (T_CYC)
    ) dut (
        .sys_clk        (sys_clk),
        .rst_n          (rst_n),
        .pll_locked     (pll_locked),
        .sdram_init_done(sdram_init_done),
        .soft_rst       (soft_rst),
        .sys_rst        (sys_rst),
        .sdram_rst      (sdram_rst),
        .cpu_rst_n      (cpu_rst_n),
        .ready          (ready),
        .init_err       (init_err)
    );

    assign outs = {sys_rst, sdram_rst, cpu_rst_n, ready, init_err};

    always #5 sys_clk = ~sys_clk;

    // Edge number since the last reset release; edge 1 is the first edge with rst_n=1.
    always @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) edge_n <= 0;
        else        edge_n <= edge_n + 1;
    end

    task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s @edge %0d: got %b expected %b", tag, edge_n, got, exp);
        end
    endtask

    task automatic expect_at(input int e, input logic [4:0] v, input string tag);
        sb_t ent;
        ent.edge_no = e;
        ent.val     = v;
        ent.tag     = tag;
        sb.push_back(ent);
    endtask

    // Drive point: 2 time units after edge k (inputs are seen at edge k+1).
    task automatic at_edge(input int k);
        while (edge_n < k) begin
            @(posedge sys_clk);
            #1;
        end
        #1;
    endtask

    // Pop and compare every expectation due at the current edge.
    always @(posedge sys_clk) begin
        sb_t ent;
        #1;
        while (sb.size() > 0 && sb[0].edge_no <= edge_n) begin
            ent = sb.pop_front();
            chk(ent.tag, outs, ent.val);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: stuck at edge %0d, %0d expectations pending", edge_n, sb.size());
        $fatal(1, "timeout");
    end

    initial begin
        rst_n           = 1'b0;
        pll_locked      = 1'b1;
        sdram_init_done = 1'b0;
        soft_rst        = 1'b0;
        #23;
        chk("reset_vals", outs, V_RST);

        // Power-up: lock before edge 1, HOLD at 3, resets fall at 11
        expect_at(2,  V_RST, "wl_e2");
        expect_at(10, V_RST, "hold_e10");
        expect_at(11, V_MID, "sdram_e11");
        expect_at(16, V_MID, "sdram_e16");
        expect_at(32, V_MID, "cpuhold_e32");
        expect_at(33, V_RUN, "run_e33");
        @(negedge sys_clk);
        rst_n = 1'b1;
        at_edge(16);
        sdram_init_done = 1'b1;
        at_edge(20);
        sdram_init_done = 1'b0;

        // Soft reset from RUN
        expect_at(36, V_RUN, "run_e36");
        expect_at(37, V_MID, "soft_e37");
        expect_at(52, V_MID, "soft_e52");
        expect_at(53, V_RUN, "soft_run_e53");
        at_edge(36);
        soft_rst = 1'b1;
        at_edge(37);
        soft_rst = 1'b0;

        // Lock loss in RUN, soft_rst coincident with locked_s low, then relock
        expect_at(59, V_RST, "unlock_e59");
        expect_at(60, V_RST, "unlock_soft_e60");
        expect_at(72, V_RST, "relock_e72");
        expect_at(73, V_MID, "relock_e73");
        at_edge(56);
        pll_locked = 1'b0;
        at_edge(58);
        soft_rst = 1'b1;
        at_edge(59);
        soft_rst = 1'b0;
        at_edge(62);
        pll_locked = 1'b1;

        // SDRAM init timeout, sticky error across the restart
        expect_at(104, V_MID,  "tmo_e104");
        expect_at(105, V_RSTE, "tmo_e105");
        expect_at(113, V_RSTE, "restart_e113");
        expect_at(114, V_MIDE, "restart_e114");
        expect_at(133, V_RUNE, "run_err_e133");
        at_edge(116);
        sdram_init_done = 1'b1;
        at_edge(120);
        sdram_init_done = 1'b0;

        // rst_n pulse mid CPU_HOLD: async reset, then REQ-019 timing again
        at_edge(135);
        soft_rst = 1'b1;
        at_edge(136);
        soft_rst = 1'b0;
        at_edge(140);
        chk("sb_drained", 5'(sb.size()), 5'd0);
        rst_n = 1'b0;
        #1;
        chk("async_rst", outs, V_RST);
        expect_at(2,  V_RST, "rst2_e2");
        expect_at(10, V_RST, "rst2_e10");
        expect_at(11, V_MID, "rst2_e11");
        repeat (2) @(negedge sys_clk);
        rst_n = 1'b1;
        at_edge(12);
        chk("sb_final", 5'(sb.size()), 5'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/rst_seq.md
RST_SEQ -- requirements
Module: rst_seq

Interface
REQ-001 The block SHALL take parameter HOLD_CYCLES, default 1024: sys_clk cycles system reset is held after PLL lock.
REQ-002 The block SHALL take parameter CPU_HOLD_CYCLES, default 4096: sys_clk cycles CPU reset is held after SDRAM init.
REQ-003 The block SHALL take parameter INIT_TIMEOUT, default 65536: max cycles waiting for sdram_init_done.
REQ-004 The block SHALL have ports, in this order:
- sys_clk  in  1  the only clock (100 MHz system clock)
- rst_n  in  1  asynchronous active-low reset (board button)
- pll_locked  in  1  AND of both PLL locks, asynchronous to sys_clk
- sdram_init_done  in  1  SDRAM controller init complete, sys_clk domain, level
- soft_rst  in  1  CPU-only reset request, one-cycle pulse, sys_clk domain
- sys_rst  out  1  active-high reset for sys_clk logic
- sdram_rst  out  1  active-high reset for SDRAM controller
- cpu_rst_n  out  1  active-low 68040 reset
- ready  out  1  sequence complete, CPU running
- init_err  out  1  sticky: SDRAM init timed out

Function
REQ-005 The block SHALL synchronise pll_locked through two sys_clk flops (locked_s); no other input is synchronised.
REQ-006 The block SHALL implement states WAIT_LOCK, HOLD, SDRAM_INIT, CPU_HOLD, RUN with one shared counter of width clog2 of the largest parameter.
REQ-007 WAIT_LOCK: all resets asserted, counter 0; locked_s=1 -> HOLD.
REQ-008 HOLD: counter increments each cycle; at counter = HOLD_CYCLES-1 -> SDRAM_INIT, counter cleared.
REQ-009 SDRAM_INIT: sys_rst=0, sdram_rst=0, cpu_rst_n=0; sdram_init_done=1 -> CPU_HOLD, counter cleared; counter = INIT_TIMEOUT-1 -> set init_err, go to WAIT_LOCK.
REQ-010 CPU_HOLD: counter increments; at counter = CPU_HOLD_CYCLES-1 -> RUN.
REQ-011 RUN: cpu_rst_n=1, ready=1; soft_rst=1 -> CPU_HOLD, counter cleared, sys_rst/sdram_rst stay 0.
REQ-012 soft_rst SHALL be ignored in every state other than RUN.
REQ-013 locked_s=0 in any state other than WAIT_LOCK SHALL force WAIT_LOCK; this takes priority over every other transition, including soft_rst and timeout.
REQ-014 All outputs SHALL be registered and decoded from the next state, so they change on the same edge as the state.
REQ-015 init_err SHALL clear only on rst_n.
REQ-016 Output levels per state (sys_rst, sdram_rst, cpu_rst_n, ready): WAIT_LOCK/HOLD 1,1,0,0; SDRAM_INIT/CPU_HOLD 0,0,0,0; RUN 0,0,1,1.

Reset
REQ-017 rst_n=0 SHALL asynchronously force state WAIT_LOCK, counter 0, both sync flops 0, sys_rst=1, sdram_rst=1, cpu_rst_n=0, ready=0, init_err=0.
REQ-018 Deassertion of rst_n SHALL be synchronous to sys_clk; the first active edge is the first edge with rst_n=1. Full sequence restarts from WAIT_LOCK.

Verification (HOLD_CYCLES=8, CPU_HOLD_CYCLES=16, INIT_TIMEOUT=32)
REQ-019 pll_locked high before edge 1 after reset release -> HOLD entered at edge 3; sys_rst and sdram_rst fall at edge 11; cpu_rst_n stays 0.
REQ-020 sdram_init_done raised 5 cycles after SDRAM_INIT entry -> CPU_HOLD next edge; cpu_rst_n and ready rise exactly 16 edges after CPU_HOLD entry.
REQ-021 In RUN, one-cycle soft_rst -> cpu_rst_n=0, ready=0 next edge, sys_rst stays 0; cpu_rst_n returns 1 after 16 edges.
REQ-022 sdram_init_done held 0 -> init_err=1 and sys_rst=1 at edge 32 after SDRAM_INIT entry; the sequence restarts and init_err stays 1 until rst_n.
REQ-023 pll_locked dropped in RUN -> all resets asserted within 3 edges; soft_rst asserted in the same cycle as locked_s falls has no effect; relock repeats REQ-019 timing.
REQ-024 rst_n pulsed low mid-CPU_HOLD -> outputs reach reset values with no clock edge; after release, sequence timing identical to REQ-019.
